// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Merges two writeback sources (source 0 = ALU, source 1 = load/store unit)
// onto one register-file write port. At most one write is issued per cycle.
//
// Optional feature macro: WB_ARB_RR_EN
//   defined   -> contended cycles are granted round-robin. last_grant records
//                the winner of the previous contended cycle, and the other
//                source wins next.
//   undefined -> source 0 always wins contended cycles, and no last_grant
//                state exists.
//
// Ports
//   clk                    : clock; all state changes on the rising edge
//   rst                    : asynchronous, active-high reset
//   s0_valid/s1_valid      : writeback request from source 0 / 1
//   s0_ready/s1_ready      : request accepted this cycle (combinational)
//   s0_rd_address/s1_...   : destination register (5 bits); x0 means drop
//   s0_rd_value/s1_...     : write data (32 bits)
//   wb_rd_address          : register-file write address; 0 means no write
//   wb_rd_value            : register-file write data; held when idle
//   conflict_count         : saturating count of contended cycles
//
// Handshake: a source holds valid/address/value stable until it sees ready=1
// in the same cycle as its valid. The transfer happens at the rising edge
// that ends that cycle. ready never depends on the wb_* outputs.
// ---------------------------------------------------------------------------
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [4:0]  s0_rd_address,
  input  logic [31:0] s0_rd_value,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [4:0]  s1_rd_address,
  input  logic [31:0] s1_rd_value,
  output logic [4:0]  wb_rd_address,
  output logic [31:0] wb_rd_value,
  output logic [15:0] conflict_count
);

  logic        eff0, eff1, contended;
  logic        grant0, grant1;
  logic [4:0]  wb_rd_address_q, wb_rd_address_d;
  logic [31:0] wb_rd_value_q, wb_rd_value_d;
  logic [15:0] conflict_count_q, conflict_count_d;

  // A request to x0 is accepted immediately, but it never competes for the port.
  assign eff0      = s0_valid && (s0_rd_address != 5'd0);
  assign eff1      = s1_valid && (s1_rd_address != 5'd0);
  assign contended = eff0 && eff1;

`ifdef WB_ARB_RR_EN
  // last_grant_q: 0 = source 0 won the last contended cycle, 1 = source 1.
  // The reset value is 1, so source 0 wins the first contention.
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant0       = eff0 && (!eff1 || last_grant_q);
    grant1       = eff1 && (!eff0 || !last_grant_q);
    last_grant_d = last_grant_q;
    if (contended) last_grant_d = grant1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    grant0 = eff0;
    grant1 = eff1 && !eff0;
  end
`endif

  // Both readies are gated by rst, so nothing is accepted while reset is held.
  assign s0_ready = !rst && s0_valid && ((s0_rd_address == 5'd0) || grant0);
  assign s1_ready = !rst && s1_valid && ((s1_rd_address == 5'd0) || grant1);

  always_comb begin
    wb_rd_address_d  = 5'd0;
    wb_rd_value_d    = wb_rd_value_q;
    conflict_count_d = conflict_count_q;
    if (grant0) begin
      wb_rd_address_d = s0_rd_address;
      wb_rd_value_d   = s0_rd_value;
    end else if (grant1) begin
      wb_rd_address_d = s1_rd_address;
      wb_rd_value_d   = s1_rd_value;
    end
    if (contended && (conflict_count_q != 16'hFFFF))
      conflict_count_d = conflict_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd_address_q  <= 5'd0;
      wb_rd_value_q    <= 32'd0;
      conflict_count_q <= 16'd0;
    end else begin
      wb_rd_address_q  <= wb_rd_address_d;
      wb_rd_value_q    <= wb_rd_value_d;
      conflict_count_q <= conflict_count_d;
    end
  end

  assign wb_rd_address  = wb_rd_address_q;
  assign wb_rd_value    = wb_rd_value_q;
  assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter. A table of vectors covers single-cycle
// behaviour: readies are checked mid-cycle, and wb outputs and conflict_count
// are checked just after the following edge. Hand-written sequences cover
// reset behaviour, mid-operation reset and counter saturation. Expectations
// follow WB_ARB_RR_EN in the same way as the design build.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_rd_address = '0, s1_rd_address = '0;
  logic [31:0] s0_rd_value = '0, s1_rd_value = '0;
  logic [4:0]  wb_rd_address;
  logic [31:0] wb_rd_value;
  logic [15:0] conflict_count;

  int total = 0;
  int bad   = 0;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s0_rd_address(s0_rd_address), .s0_rd_value(s0_rd_value),
    .s1_valid(s1_valid), .s1_ready(s1_ready),
    .s1_rd_address(s1_rd_address), .s1_rd_value(s1_rd_value),
    .wb_rd_address(wb_rd_address), .wb_rd_value(wb_rd_value),
    .conflict_count(conflict_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [15:0] cc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    s0_valid = v0; s0_rd_address = a0; s0_rd_value = d0;
    s1_valid = v1; s1_rd_address = a1; s1_rd_value = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              v0  a0  d0             v1  a1  d1        r0 r1 wa  wd             cc
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,        16'd0};
    vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 16'd0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 16'd0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 16'd0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,   1'b0, 1'b1, 5'd7, 32'h77,       16'd0};
    vecs[5]  = '{1'b1, 5'd0, 32'h5,        1'b1, 5'd3, 32'h33,   1'b1, 1'b1, 5'd3, 32'h33,       16'd0};
`ifdef WB_ARB_RR_EN
    vecs[6]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b1, 1'b0, 5'd1, 32'h11,       16'd1};
    vecs[7]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 1'b1, 5'd2, 32'h22,       16'd2};
    vecs[8]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b1, 1'b0, 5'd1, 32'h11,       16'd3};
    vecs[9]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b0, 1'b1, 5'd2, 32'h22,       16'd4};
`else
    vecs[6]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b1, 1'b0, 5'd1, 32'h11,       16'd1};
    vecs[7]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b1, 1'b0, 5'd1, 32'h11,       16'd2};
    vecs[8]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b1, 1'b0, 5'd1, 32'h11,       16'd3};
    vecs[9]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,   1'b1, 1'b0, 5'd1, 32'h11,       16'd4};
`endif
    // Both sources target x9. Source 0 wins in either mode here, then source 1 follows.
    vecs[10] = '{1'b1, 5'd9, 32'hAAAA,     1'b1, 5'd9, 32'hBBBB, 1'b1, 1'b0, 5'd9, 32'hAAAA,     16'd5};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hBBBB, 1'b0, 1'b1, 5'd9, 32'hBBBB,     16'd5};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 5'd0, 32'hBBBB,     16'd5};

    // Reset state, with a request already presented while reset is held.
    drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2);
    #2;
    chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
    chk("rst_s1_ready", {31'd0, s1_ready}, 32'd0);
    next_cycle();
    chk("rst_wb_addr", {27'd0, wb_rd_address}, 32'd0);
    chk("rst_wb_val", wb_rd_value, 32'd0);
    chk("rst_cc", {16'd0, conflict_count}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    next_cycle();
    chk("post_rst_wb_addr", {27'd0, wb_rd_address}, 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("v%0d_s0_ready", i), {31'd0, s0_ready}, {31'd0, vecs[i].r0});
      chk($sformatf("v%0d_s1_ready", i), {31'd0, s1_ready}, {31'd0, vecs[i].r1});
      next_cycle();
      chk($sformatf("v%0d_wb_addr", i), {27'd0, wb_rd_address}, {27'd0, vecs[i].wa});
      chk($sformatf("v%0d_wb_val", i), wb_rd_value, vecs[i].wd);
      chk($sformatf("v%0d_cc", i), {16'd0, conflict_count}, {16'd0, vecs[i].cc});
    end

    // Mid-cycle asynchronous reset while both sources contend.
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_s0_ready", {31'd0, s0_ready}, 32'd0);
    chk("mid_rst_s1_ready", {31'd0, s1_ready}, 32'd0);
    chk("mid_rst_wb_addr", {27'd0, wb_rd_address}, 32'd0);
    chk("mid_rst_cc", {16'd0, conflict_count}, 32'd0);
    next_cycle();
    chk("mid_rst_edge_wb_addr", {27'd0, wb_rd_address}, 32'd0);
    rst = 1'b0;
    #1;
    chk("after_rst_s0_ready", {31'd0, s0_ready}, 32'd1);
    chk("after_rst_s1_ready", {31'd0, s1_ready}, 32'd0);
    next_cycle();
    chk("after_rst_wb_addr", {27'd0, wb_rd_address}, 32'd1);
    chk("after_rst_wb_val", wb_rd_value, 32'h11);
    chk("after_rst_cc", {16'd0, conflict_count}, 32'd1);

    // Saturation: contention is held, and the count is currently 1.
    for (int n = 1; n <= 70000; n++) begin
      next_cycle();
      if (n == 65533) chk("sat_fffe", {16'd0, conflict_count}, 32'h0000FFFE);
      if (n == 65534) chk("sat_ffff", {16'd0, conflict_count}, 32'h0000FFFF);
    end
    chk("sat_hold", {16'd0, conflict_count}, 32'h0000FFFF);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    next_cycle();
    chk("sat_idle_cc", {16'd0, conflict_count}, 32'h0000FFFF);
    chk("sat_idle_wb_addr", {27'd0, wb_rd_address}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port s0_valid, input, 1 bit: source 0 (ALU) writeback request.
REQ-004 The block SHALL have the port s0_ready, output, 1 bit: source 0 request accepted this cycle.
REQ-005 The block SHALL have the port s0_rd_address, input, 5 bits: source 0 destination register.
REQ-006 The block SHALL have the port s0_rd_value, input, 32 bits: source 0 write data.
REQ-007 The block SHALL have the ports s1_valid, s1_ready, s1_rd_address and s1_rd_value, with the same directions and widths as the source 0 ports, for source 1 (load/store unit).
REQ-008 The block SHALL have the port wb_rd_address, output, 5 bits: register-file write address; 0 means no write.
REQ-009 The block SHALL have the port wb_rd_value, output, 32 bits: register-file write data.
REQ-010 The block SHALL have the port conflict_count, output, 16 bits: saturating count of contended cycles.
REQ-011 The block SHALL have no parameters; widths are fixed at 5-bit address and 32-bit data.

Function
REQ-012 The block SHALL drive a single register-file write port from two writeback sources, with at most one write per cycle.
REQ-013 A request SHALL be effective when sN_valid=1 and sN_rd_address!=0.
REQ-014 A source with sN_valid=1 and sN_rd_address=0 SHALL see sN_ready=1 in the same cycle, and SHALL produce no write and no grant.
REQ-015 With exactly one effective request, that source SHALL get ready=1 combinationally in the same cycle.
REQ-016 With two effective requests, exactly one ready SHALL be 1, chosen by the arbitration policy (REQ-025/026); the loser's ready SHALL be 0.
REQ-017 A source SHALL hold valid, address and value stable until it sees ready=1; the block is not required to tolerate violations.
REQ-018 The granted address and value SHALL be registered into wb_rd_address and wb_rd_value at the next rising clk edge (latency 1 cycle).
REQ-019 In a cycle with no grant, wb_rd_address SHALL be 0 at the next edge; wb_rd_value SHALL hold its previous value.
REQ-020 Both sources targeting the same nonzero register SHALL be serialised in grant order, so the later grant's value is the final register content.
REQ-021 The last_grant state bit SHALL update only on a contended cycle (both requests effective), and SHALL then record the winner.
REQ-022 conflict_count SHALL increment by 1 on each contended cycle.
REQ-023 conflict_count SHALL saturate at 16'hFFFF and not wrap.
REQ-024 The block SHALL NOT generate ready combinationally from wb_* outputs, so no combinational loop can form.

Configuration
REQ-025 With macro WB_ARB_RR_EN defined, contended cycles SHALL be granted round-robin to the source that is not recorded in last_grant; after reset, source 0 SHALL win the first contended cycle.
REQ-026 With WB_ARB_RR_EN undefined, source 0 SHALL always win contended cycles; last_grant SHALL be absent or ignored, and conflict_count SHALL still count contended cycles.

Reset
REQ-027 While rst=1, regardless of clk: wb_rd_address SHALL be 0, wb_rd_value 0, conflict_count 0 and last_grant pointing to source 1, so source 0 wins next.
REQ-028 While rst=1, s0_ready and s1_ready SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL drop any grant pending in that cycle, and no write SHALL be issued for it.
REQ-030 The first possible write after rst deasserts SHALL appear one edge after the first grant.

Verification
REQ-031 The bench SHALL cover a single source: s0 valid, addr 5, value 32'hDEADBEEF -> s0_ready=1 the same cycle; next cycle wb_rd_address=5, wb_rd_value=32'hDEADBEEF; the following cycle wb_rd_address=0.
REQ-032 The bench SHALL cover an x0 drop: s1 valid, addr 0, value 32'h1234 -> s1_ready=1; wb_rd_address stays 0; conflict_count unchanged.
REQ-033 The bench SHALL cover round-robin under contention: both valid for 4 cycles with s0 addr 1 and s1 addr 2, each re-requesting after acceptance, with WB_ARB_RR_EN defined -> grants s0,s1,s0,s1; wb_rd_address sequence 1,2,1,2; conflict_count=4.
REQ-034 The bench SHALL cover fixed priority: the same stimulus as REQ-033 with WB_ARB_RR_EN undefined -> all 4 grants to s0; s1_ready=0 throughout; conflict_count=4.
REQ-035 The bench SHALL cover saturation: force 70000 contended cycles -> conflict_count=16'hFFFF and remains there.
REQ-036 The bench SHALL cover reset mid-operation: rst=1 asynchronously mid-cycle while both sources are valid -> readies 0 immediately; wb_rd_address=0; conflict_count=0; after release, s0 wins the first contended cycle.
